// File: rtl/npn4_canon.sv
// npn4_canon: sequential NPN canonicalizer for 4-input Boolean functions.
//
// Accepts a 16-bit truth table f and scans all 384 (permutation, input-mask)
// candidates, one per cycle. Both output polarities are evaluated together.
// The block returns the smallest NPN-equivalent truth table g and the
// transform (p, m, o) that produces it:
//     g(x) = o ^ f(y),   y_i = x_{pi(i)} ^ m_i
// The first minimum in scan order is kept, so the reported transform is
// deterministic.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready is high only in IDLE
//   in_tt[15:0]         function f, bit k = f(x) with k = x0+2x1+4x2+8x3
//   out_valid/out_ready result handshake; the result is held while in DONE
//   out_tt[15:0]        canonical truth table g
//   out_perm[4:0]       permutation index 0..23 (lexicographic order)
//   out_mask[3:0]       input negation mask m
//   out_oneg            output negation o
//
// Parameter EARLY_EXIT: when 1, the scan stops as soon as the best candidate
// is 16'h0000. Nothing can beat zero, and the first zero is already the
// retained minimum.

module npn4_canon #(
    parameter logic EARLY_EXIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_tt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_tt,
    output logic [4:0]  out_perm,
    output logic [3:0]  out_mask,
    output logic        out_oneg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [8:0] LAST_CNT = 9'd383;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] f_reg;
    logic [8:0]  cnt;
    logic [15:0] best_tt;
    logic [4:0]  best_perm;
    logic [3:0]  best_mask;
    logic        best_oneg;

    logic [4:0]  cur_perm;
    logic [3:0]  cur_mask;
    logic [7:0]  pmap;
    logic [15:0] g0;
    logic [15:0] g1;
    logic [15:0] cand_tt;
    logic        cand_oneg;
    logic        take;
    logic [15:0] post_best;
    logic        scan_end;
    logic        accept;

    // Pack a permutation tuple (pi0,pi1,pi2,pi3) so that pi(i) sits in
    // bits [2i+1:2i].
    function automatic logic [7:0] pk(input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] c, input logic [1:0] d);
        return {d, c, b, a};
    endfunction

    // Permutation index -> tuple, lexicographic order of (pi0,pi1,pi2,pi3).
    function automatic logic [7:0] perm_map(input logic [4:0] p);
        logic [7:0] r;
        case (p)
            5'd0:    r = pk(2'd0, 2'd1, 2'd2, 2'd3);
            5'd1:    r = pk(2'd0, 2'd1, 2'd3, 2'd2);
            5'd2:    r = pk(2'd0, 2'd2, 2'd1, 2'd3);
            5'd3:    r = pk(2'd0, 2'd2, 2'd3, 2'd1);
            5'd4:    r = pk(2'd0, 2'd3, 2'd1, 2'd2);
            5'd5:    r = pk(2'd0, 2'd3, 2'd2, 2'd1);
            5'd6:    r = pk(2'd1, 2'd0, 2'd2, 2'd3);
            5'd7:    r = pk(2'd1, 2'd0, 2'd3, 2'd2);
            5'd8:    r = pk(2'd1, 2'd2, 2'd0, 2'd3);
            5'd9:    r = pk(2'd1, 2'd2, 2'd3, 2'd0);
            5'd10:   r = pk(2'd1, 2'd3, 2'd0, 2'd2);
            5'd11:   r = pk(2'd1, 2'd3, 2'd2, 2'd0);
            5'd12:   r = pk(2'd2, 2'd0, 2'd1, 2'd3);
            5'd13:   r = pk(2'd2, 2'd0, 2'd3, 2'd1);
            5'd14:   r = pk(2'd2, 2'd1, 2'd0, 2'd3);
            5'd15:   r = pk(2'd2, 2'd1, 2'd3, 2'd0);
            5'd16:   r = pk(2'd2, 2'd3, 2'd0, 2'd1);
            5'd17:   r = pk(2'd2, 2'd3, 2'd1, 2'd0);
            5'd18:   r = pk(2'd3, 2'd0, 2'd1, 2'd2);
            5'd19:   r = pk(2'd3, 2'd0, 2'd2, 2'd1);
            5'd20:   r = pk(2'd3, 2'd1, 2'd0, 2'd2);
            5'd21:   r = pk(2'd3, 2'd1, 2'd2, 2'd0);
            5'd22:   r = pk(2'd3, 2'd2, 2'd0, 2'd1);
            5'd23:   r = pk(2'd3, 2'd2, 2'd1, 2'd0);
            default: r = pk(2'd0, 2'd1, 2'd2, 2'd3);
        endcase
        return r;
    endfunction

    // g0[k] = f[j], where j_i = k_{pi(i)} ^ m_i  (output polarity o = 0).
    function automatic logic [15:0] npn_apply(input logic [15:0] f,
                                              input logic [7:0]  pm,
                                              input logic [3:0]  m);
        logic [15:0] g;
        logic [3:0]  kb;
        logic [3:0]  j;
        g = '0;
        for (int k = 0; k < 16; k++) begin
            kb = 4'(k);
            j  = '0;
            for (int i = 0; i < 4; i++) begin
                j[i] = kb[pm[2*i +: 2]] ^ m[i];
            end
            g[k] = f[j];
        end
        return g;
    endfunction

    // ---------------------------------------------------------------- datapath
    assign cur_perm = cnt[8:4];
    assign cur_mask = cnt[3:0];
    assign pmap     = perm_map(cur_perm);
    assign g0       = npn_apply(f_reg, pmap, cur_mask);
    assign g1       = ~g0;

    // g0 and g1 are complements, so they can never tie.
    assign cand_oneg = (g1 < g0);
    assign cand_tt   = cand_oneg ? g1 : g0;

    // The first candidate seeds the best register. After that, only a strictly
    // smaller candidate replaces it, so the earliest minimum is kept.
    assign take      = (cnt == 9'd0) || (cand_tt < best_tt);
    assign post_best = take ? cand_tt : best_tt;

    assign scan_end  = (cnt == LAST_CNT) ||
                       ((EARLY_EXIT == 1'b1) && (post_best == 16'h0000));

    assign accept    = (state == IDLE) && in_valid;

    // --------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (scan_end) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------- scan registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_reg     <= '0;
            cnt       <= '0;
            best_tt   <= '0;
            best_perm <= '0;
            best_mask <= '0;
            best_oneg <= 1'b0;
        end else begin
            if (accept) begin
                f_reg <= in_tt;
                cnt   <= '0;
            end
            if (state == SCAN) begin
                if (take) begin
                    best_tt   <= cand_tt;
                    best_perm <= cur_perm;
                    best_mask <= cur_mask;
                    best_oneg <= cand_oneg;
                end
                // The counter stops at the final candidate and never wraps.
                if (!scan_end) begin
                    cnt <= cnt + 9'd1;
                end
            end
        end
    end

    // The best registers change only during SCAN, so the outputs hold steady
    // for the whole DONE state.
    assign out_tt   = best_tt;
    assign out_perm = best_perm;
    assign out_mask = best_mask;
    assign out_oneg = best_oneg;

endmodule

// File: tb/tb_npn4_canon.sv
// Testbench for npn4_canon. It drives two instances, one with EARLY_EXIT=0
// and one with EARLY_EXIT=1, from shared inputs. Results are compared
// against an exhaustive reference model of the NPN scan.
module tb_npn4_canon;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_tt = '0;
    logic        out_ready = 1'b1;

    logic        in_ready0, out_valid0, out_oneg0;
    logic [15:0] out_tt0;
    logic [4:0]  out_perm0;
    logic [3:0]  out_mask0;
    logic        in_ready1, out_valid1, out_oneg1;
    logic [15:0] out_tt1;
    logic [4:0]  out_perm1;
    logic [3:0]  out_mask1;

    int checks = 0;
    int errors = 0;
    int perm_tab [24][4];

    always #5 clk = ~clk;

    npn4_canon #(.EARLY_EXIT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_tt(in_tt), .out_valid(out_valid0), .out_ready(out_ready),
        .out_tt(out_tt0), .out_perm(out_perm0), .out_mask(out_mask0), .out_oneg(out_oneg0)
    );

    npn4_canon #(.EARLY_EXIT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_tt(in_tt), .out_valid(out_valid1), .out_ready(out_ready),
        .out_tt(out_tt1), .out_perm(out_perm1), .out_mask(out_mask1), .out_oneg(out_oneg1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fill the permutation table in lexicographic order of (pi0,pi1,pi2,pi3).
    task automatic build_perms();
        int idx = 0;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 4; c++) begin
                    if (b == a || c == a || c == b) continue;
                    perm_tab[idx][0] = a;
                    perm_tab[idx][1] = b;
                    perm_tab[idx][2] = c;
                    perm_tab[idx][3] = 6 - a - b - c;
                    idx++;
                end
    endtask

    // g(x) = o ^ f(y), y_i = x_{pi(i)} ^ m_i
    function automatic logic [15:0] xform(input logic [15:0] f, input int p, input int m, input int o);
        logic [15:0] g = '0;
        for (int x = 0; x < 16; x++) begin
            int y = 0;
            for (int i = 0; i < 4; i++)
                y |= (((x >> perm_tab[p][i]) & 1) ^ ((m >> i) & 1)) << i;
            g[x] = f[y] ^ o[0];
        end
        return g;
    endfunction

    // Exhaustive scan model. fz is the first scan index where the best is zero, or -1.
    task automatic canon(input logic [15:0] f, output logic [15:0] bt,
                         output int bp, output int bm, output int bo, output int fz);
        bt = '0; bp = 0; bm = 0; bo = 0; fz = -1;
        for (int c = 0; c < 384; c++) begin
            logic [15:0] a0, a1, cand;
            int co;
            a0 = xform(f, c / 16, c % 16, 0);
            a1 = xform(f, c / 16, c % 16, 1);
            if (a1 < a0) begin cand = a1; co = 1; end
            else begin cand = a0; co = 0; end
            if (c == 0 || cand < bt) begin
                bt = cand; bp = c / 16; bm = c % 16; bo = co;
            end
            if (fz < 0 && bt == 16'h0000) fz = c;
        end
    endtask

    // One transaction on both instances. It returns the canonical result from
    // the EARLY_EXIT=0 instance.
    task automatic run(input string tag, input logic [15:0] tt, input bit stall,
                       output logic [15:0] res_tt);
        logic [15:0] e_tt, c_tt0, c_tt1;
        int e_p, e_m, e_o, fz, lat0, lat1;
        logic [4:0] c_p0, c_p1;
        logic [3:0] c_m0, c_m1;
        logic c_o0, c_o1;
        bit got0 = 0, got1 = 0, ready = 0;
        canon(tt, e_tt, e_p, e_m, e_o, fz);
        res_tt = 16'h0;
        lat0 = 0; lat1 = 0;
        c_tt0 = '0; c_tt1 = '0; c_p0 = '0; c_p1 = '0; c_m0 = '0; c_m1 = '0; c_o0 = 0; c_o1 = 0;
        out_ready = !stall;
        for (int n = 0; n < 500 && !ready; n++) begin
            @(negedge clk);
            ready = in_ready0 && in_ready1;
        end
        if (!ready) chk({tag, "_idle_timeout"}, 0, 1);
        in_tt = tt;
        in_valid = 1'b1;
        @(posedge clk);             // edge T0: accepted
        @(negedge clk);
        chk({tag, "_in_ready_busy"}, {in_ready1, in_ready0}, 0);
        in_tt = ~tt;                // must not be sampled
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_tt = 16'($urandom);
        for (int n = 1; n <= 420; n++) begin
            @(negedge clk);
            if (n == 1) chk({tag, "_busy_n1"}, in_ready0, 0);
            if (!got1 && out_valid1) begin
                got1 = 1; lat1 = n;
                c_tt1 = out_tt1; c_p1 = out_perm1; c_m1 = out_mask1; c_o1 = out_oneg1;
            end
            if (!got0 && out_valid0) begin
                got0 = 1; lat0 = n;
                c_tt0 = out_tt0; c_p0 = out_perm0; c_m0 = out_mask0; c_o0 = out_oneg0;
                if (stall) begin
                    for (int s = 0; s < 10; s++) begin
                        @(negedge clk);
                        chk({tag, "_stall_vld"}, {out_valid0, in_ready0}, 2'b10);
                        chk({tag, "_stall_hold"}, {out_tt0, out_perm0, out_mask0, out_oneg0},
                            {c_tt0, c_p0, c_m0, c_o0});
                    end
                    out_ready = 1'b1;
                    n += 10;
                end
            end
            if (!stall && got0 && n == lat0 + 1) chk({tag, "_ready_after_done"}, in_ready0, 1);
            if (got0 && got1 && in_ready0 && in_ready1) break;
        end
        if (!got0 || !got1) chk({tag, "_done_timeout"}, {got1, got0}, 2'b11);
        chk({tag, "_lat0"}, lat0, 384);
        chk({tag, "_lat1"}, lat1, (fz >= 0) ? fz + 1 : 384);
        chk({tag, "_tt0"}, c_tt0, e_tt);
        chk({tag, "_xf0"}, {c_p0, c_m0, c_o0}, {e_p[4:0], e_m[3:0], e_o[0]});
        chk({tag, "_tt1"}, c_tt1, e_tt);
        chk({tag, "_xf1"}, {c_p1, c_m1, c_o1}, {e_p[4:0], e_m[3:0], e_o[0]});
        chk({tag, "_reapply"}, xform(tt, int'(c_p0), int'(c_m0), int'(c_o0)), c_tt0);
        res_tt = c_tt0;
    endtask

    initial begin
        logic [15:0] r_ref, r_cmp, h, rt;
        int rp, rm, ro;
        build_perms();

        // Reset state
        #3;
        chk("rst_ctrl", {in_ready0, out_valid0, in_ready1, out_valid1}, 4'b1010);
        chk("rst_out", {out_tt0, out_perm0, out_mask0, out_oneg0}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run("zero", 16'h0000, 0, r_cmp);
        run("one", 16'hFFFF, 0, r_cmp);
        run("and4", 16'h8000, 0, r_cmp);
        run("lit_x0", 16'hAAAA, 0, r_cmp);

        // NPN invariance
        run("f167e", 16'h167E, 0, r_ref);
        run("f167e_n", 16'hE981, 0, r_cmp);
        chk("inv_compl", r_cmp, r_ref);
        rp = $urandom_range(0, 23);
        rm = $urandom_range(0, 15);
        ro = $urandom_range(0, 1);
        h = xform(16'h167E, rp, rm, ro);
        run("f167e_x", h, 0, r_cmp);
        chk("inv_xform", r_cmp, r_ref);

        // Random functions
        for (int t = 0; t < 3; t++) begin
            rt = 16'($urandom);
            run("rand", rt, 0, r_cmp);
        end

        // Stalled consumer
        run("stall", 16'h1E5A, 1, r_cmp);

        // Reset in mid-scan at c=200
        @(negedge clk);
        in_tt = 16'h167E;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (200) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", {in_ready0, out_valid0, in_ready1, out_valid1}, 4'b1010);
        chk("mid_rst_out", {out_tt0, out_perm0, out_mask0, out_oneg0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run("and4_post_rst", 16'h8000, 0, r_cmp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
